demux_route_sched: RTL and testbench
====================================

DEMUX_ROUTE_SCHED -- requirements
Module: demux_route_sched

Interface
REQ-001 Parameter: WIDTH, 4, data width of input beat and of each output channel.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  run request; 1 = accept traffic, 0 = stop and drain.
REQ-005 mode  input  1  0 = addressed routing (use dest), 1 = round-robin routing.
REQ-006 i  input  WIDTH  input data beat.
REQ-007 dest  input  2  destination channel in addressed mode: 00=a, 01=b, 10=c, 11=d.
REQ-008 i_valid  input  1  input beat valid.
REQ-009 i_ready  output  1  input beat accepted when i_valid and i_ready are both 1 on a rising edge.
REQ-010 a, b, c, d  output  WIDTH each  channel data; channel k drives its buffer content when full, all-zero when empty.
REQ-011 o_valid  output  4  per-channel valid; bit0=a, bit1=b, bit2=c, bit3=d.
REQ-012 o_ready  input  4  per-channel ready, same bit order.
REQ-013 busy  output  1  1 when state is not IDLE or any channel buffer is full.
REQ-014 beat_cnt  output  8  total accepted input beats, wraps 255->0.

Function
REQ-015 Each channel SHALL own a one-entry buffer (full flag + WIDTH data); o_valid[k] = full[k].
REQ-016 Channel k SHALL transfer when o_valid[k] and o_ready[k] are 1 on a rising edge; full[k] clears unless reloaded that edge.
REQ-017 FSM states SHALL be IDLE, RUN, DRAIN.
REQ-018 IDLE->RUN when en=1; on this transition mode SHALL be latched and rr_ptr SHALL be set to 0; mode changes while in RUN/DRAIN are ignored.
REQ-019 RUN->DRAIN when en=0; DRAIN->IDLE when all four full flags are 0; DRAIN->RUN when en=1 (latched mode and rr_ptr retained).
REQ-020 Target channel t SHALL be dest when latched mode=0, rr_ptr when latched mode=1.
REQ-021 i_ready SHALL be 1 only in RUN and only when full[t]=0 or o_ready[t]=1 (combinational pass-through of target drain).
REQ-022 Accepted beat SHALL appear on channel t with o_valid[t]=1 on the cycle after acceptance (latency 1).
REQ-023 Simultaneous drain and load of the same channel SHALL leave full[t]=1 holding the new beat; no beat lost or duplicated.
REQ-024 In round-robin mode rr_ptr SHALL advance by 1 per accepted beat only, wrapping 3->0; no advance when i_ready or i_valid is 0.
REQ-025 Non-target channels SHALL be unaffected by an acceptance; they drain independently.
REQ-026 beat_cnt SHALL increment by 1 per accepted beat, modulo 256.
REQ-027 In IDLE and DRAIN i_ready SHALL be 0; buffered beats still drain normally.
REQ-028 o_ready SHALL have no effect on empty channels.

Reset
REQ-029 On rst_n=0, immediately and independent of clk: state=IDLE, full=0000, all buffer data=0, a=b=c=d=0, o_valid=0000, i_ready=0, busy=0, rr_ptr=0, latched mode=0, beat_cnt=0.
REQ-030 Reset mid-operation SHALL discard all buffered beats; no output transfer completes on the edge where rst_n is low.
REQ-031 After rst_n rises, first acceptance SHALL be possible no earlier than the cycle after IDLE->RUN.

Verification
REQ-032 Addressed: mode=0, en=1, o_ready=1111, beats 0x5/dest=10 then 0x9/dest=01 -> c=0x5,o_valid=0100 one cycle later; then b=0x9,o_valid=0010; a,d stay 0; beat_cnt=2.
REQ-033 Backpressure: o_ready=0000, dest=00, send 0x3 then 0x7 -> 0x3 held on a, i_ready=0 for second beat; raise o_ready[0] -> 0x3 transfers, 0x7 loaded same edge, o_valid[0] stays 1.
REQ-034 Round-robin: mode=1, o_ready=1111, beats 0x1,0x2,0x3,0x4,0x5 -> land on a,b,c,d,a in order; rr_ptr wraps 3->0.
REQ-035 Drain: two channels full, o_ready=0000, drop en -> state DRAIN, i_ready=0, busy=1; release o_ready -> buffers empty, state IDLE, busy=0.
REQ-036 Reset mid-run: full=1010, assert rst_n=0 between edges -> o_valid=0000, a..d=0, beat_cnt=0 immediately.
REQ-037 Counter wrap: 256 accepted beats from reset -> beat_cnt=0; 257th -> beat_cnt=1.

Source files
------------

// File: rtl/demux_route_sched.sv
// demux_route_sched: routes input beats to one of four single-entry channel
// buffers. The target comes either from dest (addressed mode) or from a
// round-robin pointer.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   en                run request (1 = accept traffic, 0 = stop and drain)
//   mode              0 = addressed (dest), 1 = round-robin; latched on IDLE->RUN
//   i, dest, i_valid  input beat, destination channel, beat valid
//   i_ready           input accept (combinational)
//   a, b, c, d        channel data (zero when the channel is empty)
//   o_valid, o_ready  per-channel handshake, bit0 = a .. bit3 = d
//   busy              not IDLE, or any channel buffer holds a beat
//   beat_cnt          accepted input beats, modulo 256
module demux_route_sched #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] i,
    input  logic [1:0]       dest,
    input  logic             i_valid,
    output logic             i_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [3:0]       o_valid,
    input  logic [3:0]       o_ready,
    output logic             busy,
    output logic [7:0]       beat_cnt
);

    localparam int unsigned NCH   = 4;
    localparam int unsigned PTR_W = 2;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               mode_q, mode_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NCH-1:0]     full_q, full_d;
    logic [WIDTH-1:0]   data_q [NCH];
    logic [WIDTH-1:0]   data_d [NCH];
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic [PTR_W-1:0]   tgt_c;
    logic               accept_c;
    logic [NCH-1:0]     drain_c;
    logic [NCH-1:0]     load_c;

    // Target selection and input handshake; a full target may still accept
    // when it is draining on the same edge.
    always_comb begin
        tgt_c    = mode_q ? rr_ptr_q : dest;
        drain_c  = full_q & o_ready;
        i_ready  = (state_q == RUN) && (!full_q[tgt_c] || o_ready[tgt_c]);
        accept_c = i_valid && i_ready;
        load_c   = '0;
        if (accept_c) begin
            load_c[tgt_c] = 1'b1;
        end
    end

    // Control FSM: mode and pointer are captured only when leaving IDLE.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d  = RUN;
                    mode_d   = mode;
                    rr_ptr_d = '0;
                end
            end
            RUN: begin
                if (accept_c && mode_q) begin
                    rr_ptr_d = rr_ptr_q + PTR_W'(1);
                end
                if (!en) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (en) begin
                    state_d = RUN;
                end else if (full_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Channel buffers: a load on the draining edge keeps the entry full.
    always_comb begin
        full_d     = (full_q & ~drain_c) | load_c;
        beat_cnt_d = beat_cnt_q + CNT_W'(accept_c);
        for (int unsigned k = 0; k < NCH; k++) begin
            data_d[k] = load_c[k] ? i : data_q[k];
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            rr_ptr_q   <= '0;
            full_q     <= '0;
            beat_cnt_q <= '0;
            for (int unsigned k = 0; k < NCH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            rr_ptr_q   <= rr_ptr_d;
            full_q     <= full_d;
            beat_cnt_q <= beat_cnt_d;
            for (int unsigned k = 0; k < NCH; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    // Outputs decoded from flops only; empty channels present zero.
    assign o_valid  = full_q;
    assign a        = full_q[0] ? data_q[0] : '0;
    assign b        = full_q[1] ? data_q[1] : '0;
    assign c        = full_q[2] ? data_q[2] : '0;
    assign d        = full_q[3] ? data_q[3] : '0;
    assign busy     = (state_q != IDLE) || (|full_q);
    assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_demux_route_sched.sv
// Self-checking bench for demux_route_sched: directed vector table, directed
// multi-cycle sequences, and random traffic against a queue-based model.
module tb_demux_route_sched;

    typedef logic [3:0] beat_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        mode;
    beat_t       din;
    logic [1:0]  dest;
    logic        i_valid;
    logic        i_ready;
    beat_t       a, b, c, d;
    logic [3:0]  o_valid;
    logic [3:0]  o_ready;
    logic        busy;
    logic [7:0]  beat_cnt;

    demux_route_sched #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .i        (din),
        .dest     (dest),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .busy     (busy),
        .beat_cnt (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: state 0=idle 1=run 2=drain, one queue per channel.
    int    m_st;
    logic  m_lm;
    int    m_rr;
    int    m_cnt;
    beat_t mq [4][$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_lm = 1'b0; m_rr = 0; m_cnt = 0;
        for (int k = 0; k < 4; k++) mq[k].delete();
    endtask

    function automatic int model_tgt();
        return m_lm ? m_rr : int'(dest);
    endfunction

    function automatic logic model_irdy();
        int t;
        t = model_tgt();
        return (m_st == 1) && (mq[t].size() == 0 || o_ready[t]);
    endfunction

    function automatic beat_t model_chan(input int k);
        return (mq[k].size() != 0) ? mq[k][0] : 4'h0;
    endfunction

    task automatic check_model();
        logic [3:0] ov;
        logic       any;
        ov = '0;
        for (int k = 0; k < 4; k++) ov[k] = (mq[k].size() != 0);
        any = |ov;
        chk("i_ready", 32'(i_ready), 32'(model_irdy()));
        chk("o_valid", 32'(o_valid), 32'(ov));
        chk("a", 32'(a), 32'(model_chan(0)));
        chk("b", 32'(b), 32'(model_chan(1)));
        chk("c", 32'(c), 32'(model_chan(2)));
        chk("d", 32'(d), 32'(model_chan(3)));
        chk("busy", 32'(busy), 32'((m_st != 0) || any));
        chk("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
    endtask

    // Applies the rising-edge rules to the model using the inputs now driven.
    task automatic model_edge();
        int   t;
        logic acc;
        logic all_empty;
        t   = model_tgt();
        acc = model_irdy() && i_valid;
        all_empty = 1'b1;
        for (int k = 0; k < 4; k++) if (mq[k].size() != 0) all_empty = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (mq[k].size() != 0 && o_ready[k]) void'(mq[k].pop_front());
        end
        if (acc) begin
            mq[t].push_back(din);
            m_cnt = (m_cnt + 1) % 256;
            if (m_lm) m_rr = (m_rr + 1) % 4;
        end
        case (m_st)
            0: if (en) begin m_st = 1; m_lm = mode; m_rr = 0; end
            1: if (!en) m_st = 2;
            default: if (en) m_st = 1; else if (all_empty) m_st = 0;
        endcase
    endtask

    // Called just after a falling edge: drive, then settle before checking.
    task automatic apply(input logic e, input logic m, input logic [1:0] ds,
                         input beat_t dn, input logic v, input logic [3:0] ordy);
        en = e; mode = m; dest = ds; din = dn; i_valid = v; o_ready = ordy;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        en;
        logic        mode;
        logic [1:0]  dest;
        beat_t       din;
        logic        iv;
        logic [3:0]  ordy;
        logic        e_irdy;
        logic [3:0]  e_ov;
        logic [15:0] e_dat;   // {d,c,b,a}
        logic        e_busy;
        logic [7:0]  e_cnt;
    } vec_t;

    function automatic vec_t mkv(input logic e, input logic m, input logic [1:0] ds,
                                 input beat_t dn, input logic v, input logic [3:0] ordy,
                                 input logic irdy, input logic [3:0] ov,
                                 input logic [15:0] dat, input logic bz, input logic [7:0] cnt);
        vec_t r;
        r.en = e; r.mode = m; r.dest = ds; r.din = dn; r.iv = v; r.ordy = ordy;
        r.e_irdy = irdy; r.e_ov = ov; r.e_dat = dat; r.e_busy = bz; r.e_cnt = cnt;
        return r;
    endfunction

    vec_t vecs [13];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [3:0] exp_ov;
        beat_t      sel;

        // Addressed routing, backpressure with same-edge reload, then drain.
        vecs[0]  = mkv(1,0,2'd0,4'h0,0,4'hF, 0,4'h0,16'h0000,0,8'd0);
        vecs[1]  = mkv(1,0,2'd2,4'h5,1,4'hF, 1,4'h0,16'h0000,1,8'd0);
        vecs[2]  = mkv(1,0,2'd1,4'h9,1,4'hF, 1,4'h4,16'h0500,1,8'd1);
        vecs[3]  = mkv(1,0,2'd0,4'h0,0,4'h0, 1,4'h2,16'h0090,1,8'd2);
        vecs[4]  = mkv(1,0,2'd0,4'h3,1,4'h0, 1,4'h2,16'h0090,1,8'd2);
        vecs[5]  = mkv(1,0,2'd0,4'h7,1,4'h0, 0,4'h3,16'h0093,1,8'd3);
        vecs[6]  = mkv(1,0,2'd0,4'h7,1,4'h1, 1,4'h3,16'h0093,1,8'd3);
        vecs[7]  = mkv(1,0,2'd0,4'h0,0,4'h0, 0,4'h3,16'h0097,1,8'd4);
        vecs[8]  = mkv(0,0,2'd0,4'h0,0,4'h0, 0,4'h3,16'h0097,1,8'd4);
        vecs[9]  = mkv(0,0,2'd0,4'h0,0,4'h0, 0,4'h3,16'h0097,1,8'd4);
        vecs[10] = mkv(0,1,2'd0,4'h0,1,4'hF, 0,4'h3,16'h0097,1,8'd4);
        vecs[11] = mkv(0,0,2'd0,4'h0,0,4'hF, 0,4'h0,16'h0000,1,8'd4);
        vecs[12] = mkv(0,0,2'd0,4'h0,0,4'hF, 0,4'h0,16'h0000,0,8'd4);

        en = 1'b0; mode = 1'b0; din = '0; dest = '0; i_valid = 1'b0; o_ready = '0;
        rst_n = 1'b1;
        model_reset();

        do_reset();
        for (int r = 0; r < 13; r++) begin
            apply(vecs[r].en, vecs[r].mode, vecs[r].dest, vecs[r].din, vecs[r].iv, vecs[r].ordy);
            chk($sformatf("vec%0d i_ready", r), 32'(i_ready), 32'(vecs[r].e_irdy));
            chk($sformatf("vec%0d o_valid", r), 32'(o_valid), 32'(vecs[r].e_ov));
            chk($sformatf("vec%0d data", r), 32'({d, c, b, a}), 32'(vecs[r].e_dat));
            chk($sformatf("vec%0d busy", r), 32'(busy), 32'(vecs[r].e_busy));
            chk($sformatf("vec%0d beat_cnt", r), 32'(beat_cnt), 32'(vecs[r].e_cnt));
            check_model();
            advance();
        end

        // Round-robin: beats 1..5 land on a,b,c,d,a.
        do_reset();
        apply(1, 1, 2'd3, 4'h0, 0, 4'hF);
        advance();
        for (int n = 1; n <= 6; n++) begin
            apply(1, 0, 2'd3, beat_t'(n), (n <= 5), 4'hF);
            if (n >= 2) begin
                exp_ov = '0;
                exp_ov[(n - 2) % 4] = 1'b1;
                case ((n - 2) % 4)
                    0: sel = a;
                    1: sel = b;
                    2: sel = c;
                    default: sel = d;
                endcase
                chk($sformatf("rr beat%0d o_valid", n - 1), 32'(o_valid), 32'(exp_ov));
                chk($sformatf("rr beat%0d data", n - 1), 32'(sel), 32'(n - 1));
            end
            check_model();
            advance();
        end

        // Reset between edges with channels b and d holding beats.
        do_reset();
        apply(1, 0, 2'd0, 4'h0, 0, 4'h0);
        advance();
        apply(1, 0, 2'd1, 4'hA, 1, 4'h0);
        advance();
        apply(1, 0, 2'd3, 4'hC, 1, 4'h0);
        advance();
        apply(1, 0, 2'd0, 4'h0, 0, 4'h0);
        chk("midrun o_valid before reset", 32'(o_valid), 32'h0000_000A);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun reset o_valid", 32'(o_valid), 32'h0);
        chk("midrun reset data", 32'({d, c, b, a}), 32'h0);
        chk("midrun reset beat_cnt", 32'(beat_cnt), 32'h0);
        chk("midrun reset busy", 32'(busy), 32'h0);
        chk("midrun reset i_ready", 32'(i_ready), 32'h0);
        model_reset();
        o_ready = 4'hF;
        @(negedge clk);
        rst_n = 1'b1;
        apply(0, 0, 2'd0, 4'h0, 0, 4'hF);
        check_model();
        advance();

        // Counter wrap after 256 accepted beats.
        do_reset();
        apply(1, 1, 2'd0, 4'h0, 0, 4'hF);
        advance();
        for (int n = 0; n < 256; n++) begin
            apply(1, 1, 2'd0, beat_t'($urandom_range(0, 15)), 1, 4'hF);
            check_model();
            advance();
        end
        apply(1, 1, 2'd0, 4'h6, 1, 4'hF);
        chk("wrap beat_cnt 256", 32'(beat_cnt), 32'h0);
        advance();
        apply(1, 1, 2'd0, 4'h0, 0, 4'hF);
        chk("wrap beat_cnt 257", 32'(beat_cnt), 32'h1);
        advance();

        // Random traffic with occasional resets.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end
            apply(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), beat_t'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
            check_model();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
